quad_enc_emu_core: RTL and testbench
====================================

Name: quad_enc_emu_core

Overview:
- MMIO slot core that generates quadrature A/B waveforms and a push-switch level on PMOD output pins, emulating a rotary encoder.
- Serves as the transmit-side counterpart of the PMOD rotary-encoder input path. Its outputs are wired to ja_btm and looped back to ja_top for self-test of the encoder decoding path.
- Sits on the FPro MMIO bus behind the MCS bridge, like every other slot core in mmio_sys.

Parameters:
- CNT_W, 16, width of the period register, the step-count register and the internal timer.
- DEF_PERIOD, 50000, reset value of the period register in clk cycles (0.5 ms at 100 MHz).

Ports:
- clk  input  1  system clock, 100 MHz.
- reset  input  1  synchronous, active-high reset.
- cs  input  1  slot chip select.
- write  input  1  write strobe, qualified by cs.
- read  input  1  read strobe, qualified by cs; no side effects.
- addr  input  5  register address (reg = addr[1:0]; addr[4:2] ignored).
- wr_data  input  32  write data.
- rd_data  output  32  read data.
- enc_a  output  1  quadrature channel A, registered.
- enc_b  output  1  quadrature channel B, registered.
- enc_sw  output  1  emulated push-switch level, registered.
- busy  output  1  burst in progress, registered.

Behaviour:
- Write map (wr = cs & write):
  - reg 0: period <= wr_data[CNT_W-1:0]. A value of 0 is treated as 1.
  - reg 1: start command. N = wr_data[CNT_W-1:0]; dir = wr_data[16] (1 = CW, 0 = CCW).
  - reg 2: abort (data ignored).
  - reg 3: enc_sw <= wr_data[0].
- Read map: rd_data is a combinational mux on addr[1:0].
  - reg 0: zero-extended period.
  - reg 1: {15'b0, busy, remaining[CNT_W-1:0]}.
  - reg 2: {30'b0, enc_a, enc_b}.
  - reg 3: {31'b0, enc_sw}.
- Phase:
  - 2-bit phase register; {enc_a, enc_b} = Gray(phase), with 0->00, 1->01, 2->11, 3->10.
  - CW step: phase+1 mod 4, so B rises before A.
  - CCW step: phase-1 mod 4.
  - Wrap 3->0 and 0->3 is seamless; exactly one output bit changes per edge.
- FSM states: IDLE, RUN.
  - IDLE: busy=0. A start write with N != 0:
    - latches remaining=N and dir;
    - loads timer=period_eff-1;
    - goes to RUN; busy=1 from the next cycle.
  - IDLE, start write with N=0: no effect.
  - RUN, timer != 0: timer decrements.
  - RUN, timer == 0: phase steps per dir, remaining decrements, timer reloads with the current period_eff-1.
    - If remaining was 1, go to IDLE; busy drops the same cycle the last edge appears.
- Timing:
  - Edge k (1..N) is visible on enc_a/enc_b exactly k*period_eff cycles after the cycle in which the start write is sampled.
  - busy=1 for exactly N*period_eff cycles.
- Period writes while busy take effect at the next reload. The in-flight interval is not disturbed.
- Start writes while busy are ignored: remaining and dir are unchanged.
- Abort:
  - In RUN: IDLE on the next cycle, remaining=0, phase retained (outputs hold last level), no further edges.
  - In IDLE: no-op.
- enc_sw is independent of the FSM and may change during a burst.
- Reset values:
  - phase=0, so enc_a=0 and enc_b=0.
  - enc_sw=0, busy=0, remaining=0, timer=0, dir=0, period=DEF_PERIOD, state=IDLE.
- Reset mid-burst: all of the above within one cycle; no partial edge is emitted afterwards.
- All outputs are glitch-free because they are driven directly from flops.

Test Plan:
- Reset, then read all regs -> reg0=50000, reg1=0, reg2=0, reg3=0; enc_a=0, enc_b=0, busy=0.
- Write period=4, start N=5 CW -> edges at +4,+8,+12,+16,+20 cycles; {a,b} sequence 01,11,10,00,01; busy high for exactly 20 cycles; reg1 reads 0 at end.
- From {a,b}=01 (phase 1), start N=3 CCW with period 0 (effective 1) -> {a,b}=00,10,11 on three consecutive cycles; checks wrap 0->3 and the period-0 clamp.
- Period=10, start N=8, abort at cycle 25 -> exactly 2 edges emitted, busy=0 at cycle 26, outputs frozen; a start write at cycle 23 (while busy) is ignored.
- Period=6, start N=4; write period=2 at cycle 3 -> edges at 6, 8, 10, 12.
- Start N=100 period=3, assert reset at cycle 50 -> outputs 00, busy=0, no edges thereafter. Also toggle enc_sw via reg 3 mid-burst -> enc_sw follows one cycle after the write, and edge timing is unaffected.

Source files
------------

// File: rtl/quad_enc_emu_core.sv
// Rotary-encoder emulator slot: emits N quadrature edges on enc_a/enc_b spaced by a programmable period, plus a push-switch level.
// Register writes take effect on the sampling edge; outputs are flop-driven, reads are a combinational mux, no backpressure.
module quad_enc_emu_core #(
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        write,
    input  logic        read,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        enc_a,
    output logic        enc_b,
    output logic        enc_sw,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic [1:0]       phase_q, phase_d;
    logic [1:0]       ab_q, ab_d;
    logic             sw_q, sw_d;
    logic             busy_q, busy_d;

    logic             wr_en;
    logic [1:0]       reg_sel;
    logic [CNT_W-1:0] wr_cnt;
    logic [CNT_W-1:0] period_eff;
    logic             unused_ok;

    assign wr_en      = cs & write;
    assign reg_sel    = addr[1:0];
    assign wr_cnt     = wr_data[CNT_W-1:0];
    assign period_eff = (period_q == '0) ? ONE : period_q;
    assign unused_ok  = &{1'b0, read, addr[4:2], wr_data[31:17]};

    function automatic logic [1:0] gray(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        phase_d     = phase_q;
        sw_d        = sw_q;

        if (wr_en && reg_sel == 2'd0) period_d = wr_cnt;
        if (wr_en && reg_sel == 2'd3) sw_d = wr_data[0];

        case (state_q)
            ST_IDLE: begin
                if (wr_en && reg_sel == 2'd1 && wr_cnt != '0) begin
                    remaining_d = wr_cnt;
                    dir_d       = wr_data[16];
                    timer_d     = period_eff - ONE;
                    state_d     = ST_RUN;
                end
            end
            default: begin
                // Abort wins over a coincident step so no edge escapes after it.
                if (wr_en && reg_sel == 2'd2) begin
                    state_d     = ST_IDLE;
                    remaining_d = '0;
                    timer_d     = '0;
                end else if (timer_q != '0) begin
                    timer_d = timer_q - ONE;
                end else begin
                    phase_d     = dir_q ? phase_q + 2'd1 : phase_q - 2'd1;
                    remaining_d = remaining_q - ONE;
                    timer_d     = period_eff - ONE;
                    if (remaining_q == ONE) state_d = ST_IDLE;
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        ab_d   = gray(phase_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            period_q    <= CNT_W'(DEF_PERIOD);
            timer_q     <= '0;
            remaining_q <= '0;
            dir_q       <= 1'b0;
            phase_q     <= 2'd0;
            ab_q        <= 2'b00;
            sw_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            phase_q     <= phase_d;
            ab_q        <= ab_d;
            sw_q        <= sw_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            2'd0: rd_data[CNT_W-1:0] = period_q;
            2'd1: begin
                rd_data[CNT_W-1:0] = remaining_q;
                rd_data[16]        = busy_q;
            end
            2'd2: rd_data[1:0] = ab_q;
            default: rd_data[0] = sw_q;
        endcase
    end

    assign enc_a  = ab_q[1];
    assign enc_b  = ab_q[0];
    assign enc_sw = sw_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_quad_enc_emu_core.sv
// Bench for quad_enc_emu_core: expected edge/busy events are queued ahead of stimulus; a negedge monitor pops and compares them.
module tb_quad_enc_emu_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cs = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wr_data = '0;
    logic [31:0] rd_data;
    logic        enc_a, enc_b, enc_sw, busy;

    quad_enc_emu_core dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .write   (write),
        .read    (read),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .enc_sw  (enc_sw),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [1:0] v;
    } ev_t;

    ev_t  ab_exp[$];
    ev_t  busy_exp[$];
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;
    logic [1:0] prev_ab = 2'b00;
    logic       prev_busy = 1'b0;
    logic [1:0] seq [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic push_ab(input int c, input logic [1:0] v);
        ev_t e;
        e.c = c; e.v = v;
        ab_exp.push_back(e);
    endtask

    task automatic push_busy(input int c, input logic v);
        ev_t e;
        e.c = c; e.v = {1'b0, v};
        busy_exp.push_back(e);
    endtask

    // Monitor: every output change must match the next queued expectation, cycle and value.
    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            if ({enc_a, enc_b} !== prev_ab) begin
                if (ab_exp.size() == 0) begin
                    chk("ab_unexpected_edge", {30'b0, enc_a, enc_b}, {30'b0, prev_ab});
                end else begin
                    e = ab_exp.pop_front();
                    chk("ab_edge_cycle", cyc, e.c);
                    chk("ab_edge_value", {30'b0, enc_a, enc_b}, {30'b0, e.v});
                end
                prev_ab = {enc_a, enc_b};
            end
            if (busy !== prev_busy) begin
                if (busy_exp.size() == 0) begin
                    chk("busy_unexpected", {31'b0, busy}, {31'b0, prev_busy});
                end else begin
                    e = busy_exp.pop_front();
                    chk("busy_cycle", cyc, e.c);
                    chk("busy_value", {31'b0, busy}, {31'b0, e.v[0]});
                end
                prev_busy = busy;
            end
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] dat);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = dat;
        @(negedge clk);
        cs = 1'b0; write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cs = 1'b1; read = 1'b1; addr = a;
        #1;
        d = rd_data;
        cs = 1'b0; read = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        mon_en = 1'b1;

        // Reset state; upper address bits must be ignored.
        rd(5'b11100, d); chk("rst_reg0", d, 32'd50000);
        rd(5'd1, d);     chk("rst_reg1", d, 32'd0);
        rd(5'd2, d);     chk("rst_reg2", d, 32'd0);
        rd(5'b01011, d); chk("rst_reg3", d, 32'd0);
        chk("rst_pins", {29'b0, enc_a, enc_b, busy}, 32'd0);

        // Period 4, 5 CW steps.
        wr(5'd0, 32'd4);
        rd(5'd0, d); chk("period_rb", d, 32'd4);
        t = cyc + 1;
        push_busy(t, 1'b1); push_busy(t + 20, 1'b0);
        push_ab(t + 4, 2'b01); push_ab(t + 8, 2'b11); push_ab(t + 12, 2'b10);
        push_ab(t + 16, 2'b00); push_ab(t + 20, 2'b01);
        wr(5'd1, 32'h0001_0005);
        wait_cyc(t + 22);
        rd(5'd1, d); chk("t2_reg1_end", d, 32'd0);
        rd(5'd2, d); chk("t2_reg2_end", d, 32'd1);

        // Period 0 acts as 1; CCW 3 steps wrapping phase 0 -> 3.
        wr(5'd0, 32'd0);
        rd(5'd0, d); chk("period0_rb", d, 32'd0);
        t = cyc + 1;
        push_busy(t, 1'b1); push_busy(t + 3, 1'b0);
        push_ab(t + 1, 2'b00); push_ab(t + 2, 2'b10); push_ab(t + 3, 2'b11);
        wr(5'd1, 32'h0000_0003);
        wait_cyc(t + 6);
        rd(5'd2, d); chk("t3_reg2_end", d, 32'd3);

        // Period 10, 8 CW steps; ignored start at +23, abort at +25.
        wr(5'd0, 32'd10);
        t = cyc + 1;
        push_busy(t, 1'b1); push_busy(t + 25, 1'b0);
        push_ab(t + 10, 2'b10); push_ab(t + 20, 2'b00);
        wr(5'd1, 32'h0001_0008);
        wait_cyc(t + 22);
        wr(5'd1, 32'h0000_0002);
        rd(5'd1, d); chk("t4_start_ignored", d, 32'h0001_0006);
        wait_cyc(t + 24);
        wr(5'd2, 32'hDEAD_BEEF);
        wait_cyc(t + 45);
        rd(5'd1, d); chk("t4_reg1_aborted", d, 32'd0);
        rd(5'd2, d); chk("t4_reg2_frozen", d, 32'd0);
        wr(5'd2, 32'd0);
        rd(5'd1, d); chk("t4_idle_abort_noop", d, 32'd0);

        // Period 6, 4 CW steps; period rewritten to 2 in flight.
        wr(5'd0, 32'd6);
        t = cyc + 1;
        push_busy(t, 1'b1); push_busy(t + 12, 1'b0);
        push_ab(t + 6, 2'b01); push_ab(t + 8, 2'b11); push_ab(t + 10, 2'b10);
        push_ab(t + 12, 2'b00);
        wr(5'd1, 32'h0001_0004);
        wait_cyc(t + 2);
        wr(5'd0, 32'd2);
        wait_cyc(t + 16);

        // Zero-count start is a no-op.
        wr(5'd1, 32'h0001_0000);
        rd(5'd1, d); chk("n0_noop", d, 32'd0);

        // Period 3, 100 CW steps; switch toggled mid-burst; reset after 17 edges.
        wr(5'd0, 32'd3);
        t = cyc + 1;
        push_busy(t, 1'b1); push_busy(t + 52, 1'b0);
        for (int k = 1; k <= 17; k++) push_ab(t + 3 * k, seq[k % 4]);
        push_ab(t + 52, 2'b00);
        wr(5'd1, 32'h0001_0064);
        wait_cyc(t + 19);
        chk("sw_before", {31'b0, enc_sw}, 32'd0);
        wr(5'd3, 32'd1);
        chk("sw_after_write", {31'b0, enc_sw}, 32'd1);
        rd(5'd3, d); chk("sw_reg3", d, 32'd1);
        wait_cyc(t + 51);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_mid_pins", {29'b0, enc_a, enc_b, busy}, 32'd0);
        chk("rst_mid_sw", {31'b0, enc_sw}, 32'd0);
        rd(5'd0, d); chk("rst_mid_reg0", d, 32'd50000);
        rd(5'd1, d); chk("rst_mid_reg1", d, 32'd0);
        wait_cyc(t + 80);
        rd(5'd2, d); chk("rst_mid_reg2_late", d, 32'd0);

        chk("ab_queue_drained", ab_exp.size(), 32'd0);
        chk("busy_queue_drained", busy_exp.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
